// File: rtl/arith_pkg.sv
// Shared types and sizing for the four-function arithmetic unit.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_DIV = 2'd1,
        OP_ADD = 2'd2,
        OP_SUB = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    localparam int unsigned OPW  = 8;
    localparam int unsigned RESW = 16;
    localparam int unsigned ITER = 8;
    localparam int unsigned CNTW = $clog2(ITER);

    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(ITER - 1);

endpackage

// File: rtl/arithmetic_module_if.sv
// Start/done request bus between the ALU control FSM (master) and the arithmetic unit (slave).
interface arithmetic_module_if;

    logic                      start;
    logic [1:0]                m;
    logic [arith_pkg::OPW-1:0] X;
    logic [arith_pkg::OPW-1:0] Y;
    logic                      busy;
    logic                      done;
    logic [arith_pkg::RESW-1:0] Z;
    logic                      div_by_zero;

    modport master (
        output start, m, X, Y,
        input  busy, done, Z, div_by_zero
    );

    modport slave (
        input  start, m, X, Y,
        output busy, done, Z, div_by_zero
    );

endinterface

// File: rtl/arith_divider.sv
// Restoring divider datapath: load latches operands, each step retires one quotient bit.
// quo_nxt/rem_nxt expose the result of the step in progress so the last step can be captured directly.
module arith_divider
    import arith_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [OPW-1:0] dividend,
    input  logic [OPW-1:0] divisor,
    output logic [OPW-1:0] quo_nxt,
    output logic [OPW-1:0] rem_nxt
);

    logic [OPW-1:0] rem_q, rem_d;
    logic [OPW-1:0] quo_q, quo_d;
    logic [OPW-1:0] dvs_q, dvs_d;
    logic [OPW:0]   trial;
    logic [OPW:0]   diff;

    always_comb begin
        trial = {rem_q, quo_q[OPW-1]};
        diff  = trial - {1'b0, dvs_q};
        if (trial >= {1'b0, dvs_q}) begin
            rem_nxt = diff[OPW-1:0];
            quo_nxt = {quo_q[OPW-2:0], 1'b1};
        end else begin
            rem_nxt = trial[OPW-1:0];
            quo_nxt = {quo_q[OPW-2:0], 1'b0};
        end
    end

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            rem_d = rem_nxt;
            quo_d = quo_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/arithmetic_module.sv
// 8-bit multiply/divide/add/subtract unit with start/done handshake and 16-bit registered result.
// Build option ARITH_DIV_EN compiles in the restoring divider; without it divide returns zero.
module arithmetic_module
    import arith_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    arithmetic_module_if.slave bus
);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [OPW-1:0]  a_q, a_d;
    logic [OPW-1:0]  b_q, b_d;
    logic [RESW-1:0] acc_q, acc_d;
    logic [RESW-1:0] mcand_q, mcand_d;
    logic [OPW-1:0]  mplier_q, mplier_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [RESW-1:0] z_q, z_d;
    logic            dbz_q, dbz_d;
    logic            done_q, done_d;

    logic [RESW-1:0] partial;
    logic [RESW-1:0] calc_res;
    logic [OPW:0]    sum9;
    logic [OPW:0]    diff9;
    logic            div_load;
    logic            div_step;
    logic            busy;

`ifdef ARITH_DIV_EN
    logic [OPW-1:0] div_quo;
    logic [OPW-1:0] div_rem;

    arith_divider u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .step     (div_step),
        .dividend (a_d),
        .divisor  (b_d),
        .quo_nxt  (div_quo),
        .rem_nxt  (div_rem)
    );
`endif

    // done_q stretches busy over the pulse cycle so a new start waits for the edge after done
    assign busy = (state_q != IDLE) || done_q;

    assign sum9  = {1'b0, a_q} + {1'b0, b_q};
    assign diff9 = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        z_d      = z_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        partial  = '0;
        calc_res = '0;
        div_load = 1'b0;
        div_step = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !busy) begin
                    op_d     = op_e'(bus.m);
                    a_d      = bus.X;
                    b_d      = bus.Y;
                    acc_d    = '0;
                    mcand_d  = {{(RESW-OPW){1'b0}}, bus.X};
                    mplier_d = bus.Y;
                    cnt_d    = '0;
                    case (op_e'(bus.m))
                        OP_MUL: state_d = CALC;
`ifdef ARITH_DIV_EN
                        OP_DIV: begin
                            if (bus.Y != '0) begin
                                state_d  = CALC;
                                div_load = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end
`endif
                        default: state_d = DONE;
                    endcase
                end
            end

            CALC: begin
                cnt_d    = cnt_q + 1'b1;
                partial  = mplier_q[0] ? mcand_q : '0;
                acc_d    = acc_q + partial;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                calc_res = acc_q + partial;
`ifdef ARITH_DIV_EN
                if (op_q == OP_DIV) begin
                    div_step = 1'b1;
                    calc_res = {div_rem, div_quo};
                end
`endif
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    z_d     = calc_res;
                    dbz_d   = 1'b0;
                end
            end

            DONE: begin
                state_d = IDLE;
                // Iterative ops already pulsed done on entry; only single-cycle ops publish here
                if (!done_q) begin
                    done_d = 1'b1;
                    dbz_d  = 1'b0;
                    case (op_q)
                        OP_ADD: z_d = {{(RESW-OPW-1){1'b0}}, sum9};
                        OP_SUB: z_d = {{(RESW-OPW-1){diff9[OPW]}}, diff9};
`ifdef ARITH_DIV_EN
                        OP_DIV: begin
                            z_d   = {a_q, {OPW{1'b1}}};
                            dbz_d = 1'b1;
                        end
`endif
                        default: z_d = '0;
                    endcase
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            z_q      <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.Z           = z_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_arithmetic_module.sv
// Self-checking bench for arithmetic_module: directed vector table, handshake corner cases, random ops vs a reference model.
module tb_arithmetic_module;
    import arith_pkg::*;

    logic clk;
    logic rst_n;

    arithmetic_module_if bus ();

    arithmetic_module dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] z;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result as plain integer arithmetic: {div_by_zero, Z}
    function automatic logic [16:0] ref_model(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        int unsigned a;
        int unsigned b;
        int d;
        a = x;
        b = y;
        case (op)
            2'd0: return {1'b0, 16'(a * b)};
`ifdef ARITH_DIV_EN
            2'd1: begin
                if (b == 0) return {1'b1, x, 8'hFF};
                return {1'b0, 8'(a % b), 8'(a / b)};
            end
`else
            2'd1: return '0;
`endif
            2'd2: return {1'b0, 16'(a + b)};
            default: begin
                d = int'(a) - int'(b);
                return {1'b0, 16'(d)};
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [7:0] y);
        if (op == 2'd0) return 8;
`ifdef ARITH_DIV_EN
        if (op == 2'd1 && y != 0) return 8;
`endif
        return 1;
    endfunction

    // Caller is at posedge+1 with busy low; returns at posedge+1 one edge after done, busy low again.
    task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp_z, input logic exp_dbz, input int exp_lat);
        int lat;
        bit seen;
        bus.start = 1'b1;
        bus.m     = op;
        bus.X     = x;
        bus.Y     = y;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.m     = 2'($urandom);
        bus.X     = 8'($urandom);
        bus.Y     = 8'($urandom);
        chk({name, ".busy_rise"}, bus.busy, 1);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            lat = k;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk({name, ".timeout"}, 0, 1);
        end else begin
            chk({name, ".latency"}, lat, exp_lat);
            chk({name, ".Z"}, bus.Z, exp_z);
            chk({name, ".dbz"}, bus.div_by_zero, exp_dbz);
            chk({name, ".busy_at_done"}, bus.busy, 1);
            @(posedge clk); #1;
            chk({name, ".done_pulse"}, bus.done, 0);
            chk({name, ".busy_fall"}, bus.busy, 0);
            chk({name, ".Z_hold"}, bus.Z, exp_z);
        end
    endtask

    initial begin
        logic [16:0] r;
        logic [1:0]  op;
        logic [7:0]  x;
        logic [7:0]  y;
        int          pulses;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.m     = '0;
        bus.X     = '0;
        bus.Y     = '0;

        vecs.push_back('{2'd0, 8'd100, 8'd12,  16'h04B0, 1'b0, 8});
        vecs.push_back('{2'd0, 8'd120, 8'd120, 16'h3840, 1'b0, 8});
        vecs.push_back('{2'd0, 8'd0,   8'd0,   16'h0000, 1'b0, 8});
        vecs.push_back('{2'd0, 8'd255, 8'd255, 16'hFE01, 1'b0, 8});
`ifdef ARITH_DIV_EN
        vecs.push_back('{2'd1, 8'd50,  8'd25,  16'h0002, 1'b0, 8});
        vecs.push_back('{2'd1, 8'd10,  8'd0,   16'h0AFF, 1'b1, 1});
        vecs.push_back('{2'd1, 8'd255, 8'd7,   16'h0324, 1'b0, 8});
`else
        vecs.push_back('{2'd1, 8'd50,  8'd25,  16'h0000, 1'b0, 1});
        vecs.push_back('{2'd1, 8'd10,  8'd0,   16'h0000, 1'b0, 1});
`endif
        vecs.push_back('{2'd2, 8'd255, 8'd1,   16'h0100, 1'b0, 1});
        vecs.push_back('{2'd2, 8'd255, 8'd255, 16'h01FE, 1'b0, 1});
        vecs.push_back('{2'd3, 8'd3,   8'd5,   16'hFFFE, 1'b0, 1});
        vecs.push_back('{2'd3, 8'd255, 8'd0,   16'h00FF, 1'b0, 1});
        vecs.push_back('{2'd3, 8'd0,   8'd255, 16'hFF01, 1'b0, 1});

        #12;
        chk("reset.busy", bus.busy, 0);
        chk("reset.done", bus.done, 0);
        chk("reset.Z", bus.Z, 0);
        chk("reset.dbz", bus.div_by_zero, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].dbz, vecs[i].lat);

        // Operand change and a second start mid-multiply must not disturb the latched op
        bus.start = 1'b1;
        bus.m     = 2'd0;
        bus.X     = 8'd7;
        bus.Y     = 8'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.m     = 2'd2;
        bus.X     = 8'd200;
        bus.Y     = 8'd200;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stable.no_early_done", bus.done, 0);
        @(posedge clk); #1;
        chk("stable.done", bus.done, 1);
        chk("stable.Z", bus.Z, 16'd63);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        chk("stable.no_queued_start", pulses, 0);

        // Asynchronous reset during iteration 4 of a multiply
        bus.start = 1'b1;
        bus.m     = 2'd0;
        bus.X     = 8'd200;
        bus.Y     = 8'd100;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset.busy", bus.busy, 0);
        chk("midreset.done", bus.done, 0);
        chk("midreset.Z", bus.Z, 0);
        chk("midreset.dbz", bus.div_by_zero, 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midreset.idle_after", bus.busy, 0);
        run_op("after_reset", 2'd0, 8'd55, 8'd45, 16'h09AB, 1'b0, 8);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            x  = 8'($urandom);
            y  = (i % 8 == 0) ? 8'd0 : 8'($urandom);
            r  = ref_model(op, x, y);
            run_op($sformatf("rand%0d", i), op, x, y, r[15:0], r[16], ref_lat(op, y));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
